// File: rtl/oam_dma_ctrl.sv
// Sprite DMA bus sequencer: passes cpu accesses through when idle, otherwise halts the cpu
// and copies one 256-byte page to the OAM data port. Optional macro: OAM_DMA_ALIGN_EN.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    ALIGN,
    RD,
    WR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_latch;
  logic        r_done;
  logic        w_trigger;
  logic        w_last;
  logic        w_align;

`ifdef OAM_DMA_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end

  // Parity as seen during DUMMY decides whether one extra ALIGN cycle is spent.
  assign w_align = r_parity;
`else
  assign w_align = 1'b0;
`endif

  assign w_trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);
  assign w_last    = (r_idx == 8'hFF);

  assign cpu_halt = (r_state != IDLE);
  assign dma_busy = (r_state != IDLE);
  assign dma_done = r_done;

  always_comb begin
    w_next    = r_state;
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_we    = cpu_we;
    unique case (r_state)
      IDLE: begin
        if (w_trigger) w_next = DUMMY;
      end
      DUMMY: begin
        bus_d_out = r_latch;
        bus_we    = 1'b0;
        w_next    = w_align ? ALIGN : RD;
      end
      ALIGN: begin
        bus_d_out = r_latch;
        bus_we    = 1'b0;
        w_next    = RD;
      end
      RD: begin
        bus_addr  = {r_page, r_idx};
        bus_d_out = r_latch;
        bus_we    = 1'b0;
        w_next    = WR;
      end
      WR: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = r_latch;
        bus_we    = 1'b1;
        w_next    = w_last ? IDLE : RD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_idx   <= '0;
      r_latch <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == WR) && w_last;
      unique case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page <= cpu_d_out;
            r_idx  <= '0;
          end
        end
        RD:      r_latch <= bus_d_in;
        WR:      r_idx   <= r_idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues the expected per-cycle bus behaviour
// of each DMA; a negedge monitor pops and compares every cycle.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_d_out = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_halt;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_busy;
  logic        dma_done;

  logic [7:0] mem [65536];
  assign bus_d_in = mem[bus_addr];

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_d_out(cpu_d_out),
    .cpu_we   (cpu_we),
    .cpu_halt (cpu_halt),
    .bus_addr (bus_addr),
    .bus_d_out(bus_d_out),
    .bus_we   (bus_we),
    .bus_d_in (bus_d_in),
    .dma_busy (dma_busy),
    .dma_done (dma_done)
  );

  always #5 clk = ~clk;

  // kind: 0 = idle passthrough, 1 = halted dead cycle, 2 = source read, 3 = OAM write
  typedef struct {
    int unsigned kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned wr_seen = 0;
  bit          mon_en = 1'b0;
  logic        pbit = 1'b0;

  // Even/odd cycle tracker, counted from the last reset.
  always @(posedge clk) pbit <= rst ? 1'b0 : ~pbit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.kind = 0; e.addr = '0; e.data = '0; e.done = 1'b0;
      end
      if (e.kind == 0) begin
        chk("idle_ctrl", {29'd0, cpu_halt, dma_busy, dma_done}, {29'd0, 2'b00, e.done});
        chk("pass_addr", {16'd0, bus_addr}, {16'd0, cpu_addr});
        chk("pass_we", {31'd0, bus_we}, {31'd0, cpu_we});
        chk("pass_data", {24'd0, bus_d_out}, {24'd0, cpu_d_out});
      end else begin
        chk("busy_ctrl", {28'd0, cpu_halt, dma_busy, dma_done, bus_we},
            {28'd0, 3'b110, (e.kind == 3)});
        chk("dma_addr", {16'd0, bus_addr}, {16'd0, (e.kind == 1) ? cpu_addr : e.addr});
        if (e.kind == 3) begin
          chk("oam_data", {24'd0, bus_d_out}, {24'd0, e.data});
          wr_seen++;
        end
      end
    end
  end

  task automatic push(input int unsigned k, input logic [15:0] a, input logic [7:0] d,
                      input logic dn);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    cpu_addr  = 16'($urandom);
    if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
    cpu_we    = 1'($urandom);
    cpu_d_out = 8'($urandom);
  endtask

  // Drives the trigger write this cycle and queues the whole expected transfer.
  task automatic trigger(input logic [7:0] pg, input logic done_first,
                         output int unsigned halted);
    bit align;
    logic [15:0] a;
    cpu_addr  = 16'h4014;
    cpu_d_out = pg;
    cpu_we    = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
    align = ~pbit;
`else
    align = 1'b0;
`endif
    push(0, '0, '0, done_first);
    push(1, '0, '0, 1'b0);
    if (align) push(1, '0, '0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      a = {pg, 8'(i)};
      push(2, a, '0, 1'b0);
      push(3, 16'h2004, mem[a], 1'b0);
    end
    halted = 513 + (align ? 1 : 0);
  endtask

  task automatic ride(input int unsigned halted, input bit noise);
    for (int unsigned k = 0; k < halted; k++) begin
      step();
      if (noise) begin
        cpu_addr  = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'($urandom);
        cpu_we    = 1'($urandom);
        cpu_d_out = 8'($urandom);
      end else idle_cpu();
    end
  endtask

  task automatic finish_done();
    step();
    push(0, '0, '0, 1'b1);
    idle_cpu();
  endtask

  task automatic do_dma(input logic [7:0] pg, input bit noise);
    int unsigned h;
    trigger(pg, 1'b0, h);
    ride(h, noise);
    finish_done();
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 4)) begin
      step();
      idle_cpu();
    end
  endtask

  task automatic wait_parity(input logic want);
    for (int i = 0; i < 3 && pbit !== want; i++) begin
      step();
      idle_cpu();
    end
  endtask

  initial begin
    int unsigned h;
    int unsigned start;
    bit          hit;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;

    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // Idle passthrough of a plain write
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_d_out = 8'h5A;
    step();
    idle_cpu();
    gap();

    // Trigger on an even cycle from page 02
    wait_parity(1'b0);
    do_dma(8'h02, 1'b0);
    gap();

    // Trigger on an odd cycle
    wait_parity(1'b1);
    do_dma(8'($urandom), 1'b0);
    gap();

    // Top page: address must not carry past FFFF
    do_dma(8'hFF, 1'b0);
    gap();

    // cpu writes to the DMA register while busy must be ignored
    do_dma(8'($urandom), 1'b1);
    gap();

    // Completion and a new trigger in the same cycle
    trigger(8'h37, 1'b0, h);
    ride(h, 1'b0);
    step();
    trigger(8'hC4, 1'b1, h);
    ride(h, 1'b0);
    finish_done();
    gap();

    // Reset during the 100th OAM write, then restart from index 0
    trigger(8'h81, 1'b0, h);
    start = wr_seen;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (wr_seen - start >= 100) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_100wr: got %0d writes expected 100 within bound", wr_seen - start);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cpu();
    step();
    idle_cpu();
    do_dma(8'h81, 1'b0);
    gap();

    // Two more random transfers with random spacing
    for (int r = 0; r < 2; r++) begin
      do_dma(8'($urandom), 1'($urandom));
      gap();
    end

    repeat (4) begin
      step();
      idle_cpu();
    end
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
